// File: rtl/lock_pkg.sv
// Shared definitions for the door-lock sequencing controller.
// Contents: FSM state type, special key codes, entry width and default
// timing constants, plus a digit-classification helper.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_VERIFY,
    ST_UNLOCKED,
    ST_SET_PW,
    ST_LOCKOUT
  } lock_state_t;

  localparam logic [3:0]  KEY_STAR           = 4'hA;
  localparam logic [3:0]  KEY_SHARP          = 4'hB;
  localparam int unsigned ENTRY_DIGITS       = 4;

  localparam int unsigned DEF_MAX_WRONG      = 5;
  localparam int unsigned DEF_LOCKOUT_CYCLES = 1000;
  localparam int unsigned DEF_RELOCK_CYCLES  = 5000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 3000;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/lock_seq_ctrl_if.sv
// Keypad, comparator and password-register signals of the lock controller.
//   key_valid/key_code : keypad strobe and code
//   cmp_req/cmp_ack/cmp_match/display : compare handshake and entry word
//   pw_we/pw_new       : password register write strobe and data
// slave  : the controller side
// master : the environment (keypad, comparator, password register) side
interface lock_seq_ctrl_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        cmp_req;
  logic        cmp_ack;
  logic        cmp_match;
  logic [15:0] display;
  logic        pw_we;
  logic [15:0] pw_new;

  modport slave (
    input  key_valid, key_code, cmp_ack, cmp_match,
    output cmp_req, display, pw_we, pw_new
  );

  modport master (
    output key_valid, key_code, cmp_ack, cmp_match,
    input  cmp_req, display, pw_we, pw_new
  );
endinterface

// File: rtl/lock_timer.sv
// Loadable saturating down-counter.
//   clk, reset : clock, asynchronous active-high reset
//   i_start    : load CYCLES (has priority over i_stop)
//   i_stop     : clear the counter
//   o_expire   : high during the last counted cycle, so an action taken on
//                it lands exactly CYCLES edges after the load edge
module lock_timer #(
  parameter int unsigned CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_stop,
  output logic o_expire
);
  localparam int unsigned W = $clog2(CYCLES + 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_start) begin
      r_count <= W'(CYCLES);
    end else if (i_stop) begin
      r_count <= '0;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expire = (r_count == W'(1));
endmodule

// File: rtl/lock_seq_ctrl.sv
// Sequencing controller for the door-lock password comparator.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   bus (slave)  : keypad, compare handshake, display, password write
//   close_sensor : door-closed level
//   alert_off    : operator alert clear
//   unlock       : bolt release level
//   alert        : alarm level
//   wrong_cnt    : consecutive failed attempts
// Optional feature macro: LOCK_ENTRY_TIMEOUT_EN (inactivity timeout of a
// partial entry in ENTRY / SET_PW).
module lock_seq_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned MAX_WRONG      = DEF_MAX_WRONG,
  parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int unsigned RELOCK_CYCLES  = DEF_RELOCK_CYCLES
`ifdef LOCK_ENTRY_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  lock_seq_ctrl_if.slave        bus,
  input  logic                  close_sensor,
  input  logic                  alert_off,
  output logic                  unlock,
  output logic                  alert,
  output logic [2:0]            wrong_cnt
);
  localparam logic [2:0] FULL_CNT  = 3'(ENTRY_DIGITS);
  localparam logic [2:0] LAST_FAIL = 3'(MAX_WRONG - 1);

  lock_state_t r_state;
  logic [15:0] r_display;
  logic [2:0]  r_cnt;
  logic        r_cmp_req;
  logic        r_unlock;
  logic        r_alert;
  logic        r_pw_we;
  logic [15:0] r_pw_new;
  logic [2:0]  r_wrong_cnt;
  logic        r_close_q;

  logic w_digit, w_star, w_sharp, w_full;
  logic w_rise, w_fall;
  logic w_fail, w_lock;
  logic w_lo_expire, w_rl_expire, w_rl_start, w_rl_stop;
  logic w_to_hit;

  always_comb begin
    w_digit    = bus.key_valid && is_digit(bus.key_code);
    w_star     = bus.key_valid && (bus.key_code == KEY_STAR);
    w_sharp    = bus.key_valid && (bus.key_code == KEY_SHARP);
    w_full     = (r_cnt == FULL_CNT);
    w_rise     = close_sensor && !r_close_q;
    w_fall     = !close_sensor && r_close_q;
    // A short '*' and a rejected compare share the same failure path.
    w_fail     = ((r_state == ST_ENTRY) && w_star && !w_full) ||
                 ((r_state == ST_VERIFY) && bus.cmp_ack && !bus.cmp_match);
    w_lock     = w_fail && (r_wrong_cnt == LAST_FAIL);
    w_rl_start = ((r_state == ST_VERIFY) && bus.cmp_ack && bus.cmp_match) ||
                 ((r_state == ST_SET_PW) && (w_sharp || w_to_hit));
    w_rl_stop  = w_fall || (r_state != ST_UNLOCKED);
  end

  lock_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lockout (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_lock),
    .i_stop   (1'b0),
    .o_expire (w_lo_expire)
  );

  lock_timer #(.CYCLES(RELOCK_CYCLES)) u_relock (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_rl_start),
    .i_stop   (w_rl_stop),
    .o_expire (w_rl_expire)
  );

`ifdef LOCK_ENTRY_TIMEOUT_EN
  logic w_to_start, w_to_expire;
  // Held loaded outside the entry states and reloaded by any key press.
  assign w_to_start = bus.key_valid ||
                      !((r_state == ST_ENTRY) || (r_state == ST_SET_PW));
  lock_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_to_start),
    .i_stop   (1'b0),
    .o_expire (w_to_expire)
  );
  assign w_to_hit = w_to_expire && !bus.key_valid;
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_display   <= '0;
      r_cnt       <= '0;
      r_cmp_req   <= 1'b0;
      r_unlock    <= 1'b0;
      r_alert     <= 1'b0;
      r_pw_we     <= 1'b0;
      r_pw_new    <= '0;
      r_wrong_cnt <= '0;
      r_close_q   <= 1'b0;
    end else begin
      r_cmp_req <= 1'b0;
      r_pw_we   <= 1'b0;
      r_close_q <= close_sensor;
      if (alert_off) r_alert <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_digit) begin
            r_display <= {r_display[11:0], bus.key_code};
            r_cnt     <= 3'd1;
            r_state   <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (w_to_hit || w_sharp) begin
            r_display <= '0;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end else if (w_digit) begin
            r_display <= {r_display[11:0], bus.key_code};
            if (!w_full) r_cnt <= r_cnt + 3'd1;
          end else if (w_star && w_full) begin
            r_cmp_req <= 1'b1;
            r_state   <= ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (bus.cmp_ack && bus.cmp_match) begin
            r_unlock    <= 1'b1;
            r_wrong_cnt <= '0;
            r_display   <= '0;
            r_cnt       <= '0;
            r_state     <= ST_UNLOCKED;
          end
        end
        ST_UNLOCKED: begin
          if (w_rise || (w_rl_expire && close_sensor)) begin
            r_unlock <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (w_sharp) begin
            r_display <= '0;
            r_cnt     <= '0;
            r_state   <= ST_SET_PW;
          end
        end
        ST_SET_PW: begin
          if (w_to_hit || w_sharp) begin
            r_display <= '0;
            r_cnt     <= '0;
            r_state   <= ST_UNLOCKED;
          end else if (w_digit) begin
            r_display <= {r_display[11:0], bus.key_code};
            if (!w_full) r_cnt <= r_cnt + 3'd1;
          end else if (w_star && w_full) begin
            r_pw_new  <= r_display;
            r_pw_we   <= 1'b1;
            r_unlock  <= 1'b0;
            r_display <= '0;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end
        end
        ST_LOCKOUT: begin
          if (w_lo_expire) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // Failure handling overrides the per-state updates above; setting the
      // alert here also makes it win over a simultaneous alert_off.
      if (w_fail) begin
        r_display <= '0;
        r_cnt     <= '0;
        if (w_lock) begin
          r_alert     <= 1'b1;
          r_wrong_cnt <= '0;
          r_state     <= ST_LOCKOUT;
        end else begin
          r_wrong_cnt <= r_wrong_cnt + 3'd1;
          r_state     <= ST_IDLE;
        end
      end
    end
  end

  assign bus.display = r_display;
  assign bus.cmp_req = r_cmp_req;
  assign bus.pw_we   = r_pw_we;
  assign bus.pw_new  = r_pw_new;
  assign unlock      = r_unlock;
  assign alert       = r_alert;
  assign wrong_cnt   = r_wrong_cnt;
endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed bench for lock_seq_ctrl: a vector table for single-cycle
// behaviour, then hand-written lockout, relock, abort, door and reset
// sequences. Timeout sequence included when LOCK_ENTRY_TIMEOUT_EN is set.
module tb_lock_seq_ctrl;
  import lock_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       close_sensor;
  logic       alert_off;
  logic       unlock;
  logic       alert;
  logic [2:0] wrong_cnt;

  lock_seq_ctrl_if bus ();

  lock_seq_ctrl #(
    .MAX_WRONG      (5),
    .LOCKOUT_CYCLES (1000),
    .RELOCK_CYCLES  (5000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .close_sensor (close_sensor),
    .alert_off    (alert_off),
    .unlock       (unlock),
    .alert        (alert),
    .wrong_cnt    (wrong_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        kv;
    logic [3:0]  kc;
    logic        ack;
    logic        match;
    logic [15:0] e_disp;
    logic        e_req;
    logic        e_unl;
    logic        e_alert;
    logic [2:0]  e_wc;
    logic        e_we;
    logic [15:0] e_pwn;
  } vec_t;

  vec_t vt [48];
  int   nv = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // {display, cmp_req, unlock, alert, wrong_cnt, pw_we, pw_new}
  function automatic logic [63:0] outs();
    return {25'd0, bus.display, bus.cmp_req, unlock, alert, wrong_cnt, bus.pw_we, bus.pw_new};
  endfunction

  task automatic add(input logic kv, input logic [3:0] kc, input logic ack, input logic m,
                     input logic [15:0] d, input logic rq, input logic ul, input logic al,
                     input logic [2:0] wc, input logic we, input logic [15:0] pn);
    vt[nv] = '{kv, kc, ack, m, d, rq, ul, al, wc, we, pn};
    nv++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic attempt(input logic [15:0] code, input logic m, input logic aoff);
    for (int j = 0; j < 4; j++) key(code[15-4*j -: 4]);
    key(KEY_STAR);
    chk("attempt_req", {47'd0, bus.cmp_req, bus.display}, {47'd0, 1'b1, code});
    tick();
    bus.cmp_ack   = 1'b1;
    bus.cmp_match = m;
    alert_off     = aoff;
    tick();
    bus.cmp_ack   = 1'b0;
    bus.cmp_match = 1'b0;
    alert_off     = 1'b0;
  endtask

  initial begin
    int bad;
    int n;
    bit done;
    logic [3:0] seq [6];
    logic [63:0] exp;

    reset = 1'b1; close_sensor = 1'b1; alert_off = 1'b0;
    bus.key_valid = 1'b0; bus.key_code = '0; bus.cmp_ack = 1'b0; bus.cmp_match = 1'b0;

    //   kv kc    ak m  disp      rq ul al wc we pw_new
    add(1, 4'h1, 0, 0, 16'h0001, 0, 0, 0, 0, 0, 16'h0000);
    add(1, 4'h2, 0, 0, 16'h0012, 0, 0, 0, 0, 0, 16'h0000);
    add(1, 4'h3, 0, 0, 16'h0123, 0, 0, 0, 0, 0, 16'h0000);
    add(1, 4'h4, 0, 0, 16'h1234, 0, 0, 0, 0, 0, 16'h0000);
    add(1, 4'hA, 0, 0, 16'h1234, 1, 0, 0, 0, 0, 16'h0000);
    add(0, 4'h0, 0, 0, 16'h1234, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 4'h0, 1, 1, 16'h0000, 0, 1, 0, 0, 0, 16'h0000);
    add(1, 4'hB, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 16'h0000);
    add(1, 4'h9, 0, 0, 16'h0009, 0, 1, 0, 0, 0, 16'h0000);
    add(1, 4'h8, 0, 0, 16'h0098, 0, 1, 0, 0, 0, 16'h0000);
    add(1, 4'h7, 0, 0, 16'h0987, 0, 1, 0, 0, 0, 16'h0000);
    add(1, 4'h6, 0, 0, 16'h9876, 0, 1, 0, 0, 0, 16'h0000);
    add(1, 4'hA, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 16'h9876);
    add(0, 4'h0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 16'h9876);
    add(1, 4'h1, 0, 0, 16'h0001, 0, 0, 0, 0, 0, 16'h9876);
    add(1, 4'h2, 0, 0, 16'h0012, 0, 0, 0, 0, 0, 16'h9876);
    add(1, 4'h3, 0, 0, 16'h0123, 0, 0, 0, 0, 0, 16'h9876);
    add(1, 4'h4, 0, 0, 16'h1234, 0, 0, 0, 0, 0, 16'h9876);
    add(1, 4'h5, 0, 0, 16'h2345, 0, 0, 0, 0, 0, 16'h9876);
    add(1, 4'h6, 0, 0, 16'h3456, 0, 0, 0, 0, 0, 16'h9876);
    add(1, 4'hA, 0, 0, 16'h3456, 1, 0, 0, 0, 0, 16'h9876);
    add(0, 4'h0, 1, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h9876);
    add(1, 4'h1, 0, 0, 16'h0001, 0, 0, 0, 1, 0, 16'h9876);
    add(1, 4'h2, 0, 0, 16'h0012, 0, 0, 0, 1, 0, 16'h9876);
    add(1, 4'hA, 0, 0, 16'h0000, 0, 0, 0, 2, 0, 16'h9876);
    add(1, 4'hA, 0, 0, 16'h0000, 0, 0, 0, 2, 0, 16'h9876);
    add(1, 4'h7, 0, 0, 16'h0007, 0, 0, 0, 2, 0, 16'h9876);
    add(1, 4'hB, 0, 0, 16'h0000, 0, 0, 0, 2, 0, 16'h9876);
    add(1, 4'h5, 0, 0, 16'h0005, 0, 0, 0, 2, 0, 16'h9876);
    add(1, 4'h5, 0, 0, 16'h0055, 0, 0, 0, 2, 0, 16'h9876);
    add(1, 4'h5, 0, 0, 16'h0555, 0, 0, 0, 2, 0, 16'h9876);
    add(1, 4'h5, 0, 0, 16'h5555, 0, 0, 0, 2, 0, 16'h9876);
    add(1, 4'hA, 0, 0, 16'h5555, 1, 0, 0, 2, 0, 16'h9876);
    add(1, 4'h9, 0, 0, 16'h5555, 0, 0, 0, 2, 0, 16'h9876);
    add(1, 4'h1, 1, 0, 16'h0000, 0, 0, 0, 3, 0, 16'h9876);
    add(1, 4'h1, 0, 0, 16'h0001, 0, 0, 0, 3, 0, 16'h9876);
    add(1, 4'hA, 0, 0, 16'h0000, 0, 0, 0, 4, 0, 16'h9876);
    add(1, 4'h2, 0, 0, 16'h0002, 0, 0, 0, 4, 0, 16'h9876);
    add(1, 4'hA, 0, 0, 16'h0000, 0, 0, 1, 0, 0, 16'h9876);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", outs(), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < nv; i++) begin
      bus.key_valid = vt[i].kv;
      bus.key_code  = vt[i].kc;
      bus.cmp_ack   = vt[i].ack;
      bus.cmp_match = vt[i].match;
      tick();
      exp = {25'd0, vt[i].e_disp, vt[i].e_req, vt[i].e_unl, vt[i].e_alert,
             vt[i].e_wc, vt[i].e_we, vt[i].e_pwn};
      chk($sformatf("vec%0d", i), outs(), exp);
    end
    bus.key_valid = 1'b0; bus.cmp_ack = 1'b0; bus.cmp_match = 1'b0;

    // First lockout: keys ignored for exactly 1000 cycles, alert held.
    bad = 0;
    bus.key_valid = 1'b1; bus.key_code = 4'h3;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (bus.display !== 16'h0 || alert !== 1'b1) bad++;
    end
    chk("lockout1_hold", 64'(bad), 64'd0);
    tick();
    bus.key_valid = 1'b0;
    chk("lockout1_end", 64'(bus.display), 64'h0003);
    chk("alert_persists", 64'(alert), 64'd1);
    key(KEY_SHARP);
    alert_off = 1'b1;
    tick();
    alert_off = 1'b0;
    chk("alert_off", 64'(alert), 64'd0);

    // Five rejected compares; alert_off coinciding with the 5th loses.
    for (int a = 0; a < 5; a++) begin
      attempt(16'h1111, 1'b0, a == 4);
      if (a < 4) chk($sformatf("wrong_cnt%0d", a), 64'(wrong_cnt), 64'(a + 1));
    end
    chk("set_wins", 64'({alert, wrong_cnt}), 64'({1'b1, 3'd0}));

    // alert_off mid-lockout clears the alarm but not the lockout.
    bad = 0;
    bus.key_valid = 1'b1; bus.key_code = 4'h3;
    for (int c = 0; c < 1000; c++) begin
      alert_off = (c == 10);
      tick();
      if (bus.display !== 16'h0) bad++;
    end
    alert_off = 1'b0;
    chk("lockout2_hold", 64'(bad), 64'd0);
    chk("lockout2_alert", 64'(alert), 64'd0);
    tick();
    bus.key_valid = 1'b0;
    chk("lockout2_end", 64'(bus.display), 64'h0003);
    key(KEY_SHARP);

    // Timed relock with the door held closed.
    attempt(16'h2468, 1'b1, 1'b0);
    chk("unlocked", 64'({unlock, wrong_cnt, bus.display}), 64'({1'b1, 3'd0, 16'h0}));
    n = 0; done = 1'b0;
    while (!done && n < 6000) begin
      tick();
      n++;
      if (!unlock) done = 1'b1;
    end
    chk("relock_cycles", 64'(n), 64'd5000);

    // Password change aborted with '#'.
    attempt(16'h2468, 1'b1, 1'b0);
    seq = '{KEY_SHARP, 4'h9, 4'h8, 4'h7, 4'h6, KEY_SHARP};
    bad = 0;
    for (int j = 0; j < 6; j++) begin
      key(seq[j]);
      if (bus.pw_we !== 1'b0) bad++;
    end
    chk("abort_no_we", 64'(bad), 64'd0);
    chk("abort_state", 64'({unlock, bus.display, bus.pw_new}), 64'({1'b1, 16'h0, 16'h9876}));

    // Door opened then closed: relock on the close edge.
    close_sensor = 1'b0;
    repeat (20) tick();
    chk("door_open_held", 64'(unlock), 64'd1);
    close_sensor = 1'b1;
    tick();
    chk("close_edge", 64'(unlock), 64'd0);

    // Reset while in VERIFY, then a late ack.
    key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    key(KEY_STAR);
    chk("verify_req", 64'(bus.cmp_req), 64'd1);
    tick();
    #2 reset = 1'b1;
    #1 chk("async_reset", outs(), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.cmp_ack = 1'b1; bus.cmp_match = 1'b1;
    tick();
    bus.cmp_ack = 1'b0; bus.cmp_match = 1'b0;
    chk("late_ack", outs(), 64'd0);
    key(4'h1);
    chk("idle_after_reset", 64'(bus.display), 64'h0001);
    key(KEY_SHARP);

`ifdef LOCK_ENTRY_TIMEOUT_EN
    key(4'h5);
    bad = 0;
    for (int c = 0; c < 2999; c++) begin
      tick();
      if (bus.display !== 16'h0005) bad++;
    end
    chk("timeout_hold", 64'(bad), 64'd0);
    tick();
    chk("timeout_clear", 64'({bus.display, wrong_cnt}), 64'({16'h0, 3'd0}));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lock_seq_ctrl.md
Name: lock_seq_ctrl

Overview:
- Sequencing controller for the door-lock password comparator.
- Collects keypad digits into a 16-bit BCD entry word and issues compare requests on '*'.
- Tracks wrong attempts, drives the alert/lockout and timed relock.
- Runs the password-change flow and presents the write strobe to the password register.

Parameters:
- MAX_WRONG, 5: consecutive failed compares that trigger alert and lockout.
- LOCKOUT_CYCLES, 1000: clk cycles keypad stays ignored after alert.
- RELOCK_CYCLES, 5000: clk cycles in UNLOCKED with door still closed before automatic relock.
- TIMEOUT_CYCLES, 3000: inactivity limit for a partial entry (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe, key_code valid.
- key_code  in  4  0-9 digit, 4'hA '*', 4'hB '#', others ignored.
- cmp_ack  in  1  comparator result valid, one cycle.
- cmp_match  in  1  entry matched stored or temp password; valid with cmp_ack.
- close_sensor  in  1  door closed level.
- alert_off  in  1  operator clears alert.
- display  out  16  current BCD entry, newest digit in [3:0].
- cmp_req  out  1  one-cycle compare request.
- unlock  out  1  bolt release level.
- alert  out  1  alarm level.
- pw_we  out  1  one-cycle password write strobe.
- pw_new  out  16  new password, valid with pw_we.
- wrong_cnt  out  3  consecutive failures.

Behaviour:
- Reset: all outputs 0; state IDLE; digit count 0; all timers 0.
- Digit entry:
  - A digit key in IDLE/ENTRY shifts display left by 4 and inserts the digit.
  - Digit count saturates at 4. Extra digits keep shifting, so the last 4 digits are retained.
- States and transitions:
  - IDLE: first digit -> ENTRY. '*' with 0 digits is ignored.
  - ENTRY: '*' with count==4 -> VERIFY, cmp_req=1 for exactly one cycle. '*' with count<4 counts as a failure without a request. '#' clears display/count -> IDLE.
  - VERIFY: keys ignored.
    - On cmp_ack with match: -> UNLOCKED; unlock=1; wrong_cnt=0; display cleared.
    - On cmp_ack without match: wrong_cnt+1, display cleared.
    - When wrong_cnt reaches MAX_WRONG: alert=1, wrong_cnt=0 -> LOCKOUT; otherwise -> IDLE.
  - UNLOCKED:
    - close_sensor falling (door opened) stops the relock timer.
    - close_sensor rising, or relock timer expiry while closed: unlock=0 -> IDLE.
    - '#' -> SET_PW: display cleared, unlock held.
  - SET_PW:
    - 4 digits, then '*': pw_new=display, pw_we=1 for one cycle, unlock=0 -> IDLE.
    - '#' aborts -> UNLOCKED without pw_we.
  - LOCKOUT:
    - Keys ignored; counter runs LOCKOUT_CYCLES, then -> IDLE.
    - alert stays 1 until alert_off, independent of state. alert_off does not end lockout early.
- Simultaneous events:
  - key_valid in the same cycle as cmp_ack: key dropped.
  - alert_off in the same cycle alert is being set: set wins.
- Reset mid-operation aborts everything. A pending cmp_ack after reset is ignored.
- Timers are saturating counters sized by $clog2 of their parameter.
- Compare latency is unconstrained; VERIFY waits indefinitely for cmp_ack.

Optional Feature:
- Macro: LOCK_ENTRY_TIMEOUT_EN.
- Defined: in ENTRY or SET_PW, TIMEOUT_CYCLES without key_valid clears display/count. ENTRY -> IDLE; SET_PW -> UNLOCKED. Not counted as a failure.
- Undefined: partial entry persists indefinitely; no timeout counter is synthesized.

Decomposition:
- Shared package lock_pkg:
  - State enum.
  - KEY_STAR=4'hA, KEY_SHARP=4'hB.
  - Default timing constants.
  - ENTRY_DIGITS=4.
- One natural sub-module: lock_timer, a loadable down-counter with start/expire. Instanced for lockout, relock and optional timeout.

Test Plan:
- Keys 1,2,3,4,'*'; cmp_ack with match=1 two cycles later -> cmp_req single pulse with display=16'h1234; unlock=1 next cycle; wrong_cnt=0.
- Five wrong entries, each acked with match=0 -> wrong_cnt counts 1..4; on the 5th, alert=1, wrong_cnt=0, LOCKOUT. Keys ignored for 1000 cycles, then IDLE. alert cleared only by alert_off.
- Keys 1..6 then '*' -> cmp_req with display=16'h3456. Keys 1,2,'*' -> no cmp_req, wrong_cnt=1.
- Unlocked; '#', 9,8,7,6, '*' -> pw_we pulse, pw_new=16'h9876, unlock=0, IDLE. Same sequence with '#' instead of the final '*' -> no pw_we, remains UNLOCKED.
- Unlocked with close_sensor held 1 -> unlock drops after exactly RELOCK_CYCLES. Door opened, then closed -> unlock drops on the close edge.
- reset asserted while in VERIFY, then a late cmp_ack -> all outputs 0, state IDLE, ack ignored. With LOCK_ENTRY_TIMEOUT_EN: key 5 then idle 3000 cycles -> display=0, wrong_cnt unchanged.
